// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between instruction fetch (IF)
// and the MEM stage. It generates the pipeline stall controls and buffers
// one fetched instruction word, so a fetch that completes while the MEM
// stage is stalled is not lost.
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-low reset
//   if_req, if_addr           fetch request and PC
//   if_rdata, if_valid        buffered instruction word and its valid flag
//   memRead_MEM, memWrite_MEM MEM-stage load/store request
//   addr_MEM, wdata_MEM       load/store address and store data
//   rdata_MEM, mem_done       load result; mem_done pulses for one cycle
//   stall_IF, stall_MEM       pipeline freeze controls
//   ram_req/we/addr/wdata     memory request side
//   ram_rdata, ram_ack        memory response side
//   bus_err                   sticky timeout flag
//   state_dbg                 current FSM state (IDLE=0, MEM_ACC=1, MEM_DONE=2, IF_ACC=3)
//
// Memory handshake: ram_req rises at a clock edge. ram_we, ram_addr and
// ram_wdata are stable while ram_req=1. The memory pulses ram_ack for
// exactly one cycle, with ram_rdata valid in that cycle. ram_req drops at
// the edge that closes the ack cycle. If no ack arrives within MAX_WAIT
// request cycles, the request is withdrawn and bus_err is set. ram_ack
// seen while no request is outstanding is ignored.
module mem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              memRead_MEM,
  input  logic              memWrite_MEM,
  input  logic [DATA_W-1:0] addr_MEM,
  input  logic [DATA_W-1:0] wdata_MEM,
  output logic [DATA_W-1:0] rdata_MEM,
  output logic              mem_done,
  output logic              stall_IF,
  output logic              stall_MEM,
  output logic              ram_req,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              bus_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_ACC  = 2'd1,
    MEM_DONE = 2'd2,
    IF_ACC   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              buf_full;
  logic              mem_op;
  logic              in_acc;
  logic              timeout;
  logic              finish;
  logic [DATA_W-1:0] fin_data;

  assign mem_op  = memRead_MEM | memWrite_MEM;
  assign in_acc  = (state == MEM_ACC) || (state == IF_ACC);
  // wait_cnt holds the number of request cycles already elapsed, so a value
  // of MAX_WAIT-1 marks the last permitted cycle of the access.
  assign timeout = in_acc && !ram_ack && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
  assign finish  = in_acc && (ram_ack || timeout);
  // An aborted access completes as if acked with a zero read word.
  assign fin_data = ram_ack ? ram_rdata : '0;

  // Stalls are forced low while reset is asserted.
  assign stall_MEM = rst & mem_op & (state != MEM_DONE);
  assign stall_IF  = rst & if_req & ~buf_full;
  assign mem_done  = (state == MEM_DONE);
  assign if_valid  = buf_full;
  assign state_dbg = state;

  // Next-state logic. MEM wins a simultaneous request because it is the
  // older instruction; a fetch is not issued while a word is buffered.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_op) begin
          state_nxt = MEM_ACC;
        end else if (if_req && !buf_full) begin
          state_nxt = IF_ACC;
        end
      end
      MEM_ACC:  if (finish) state_nxt = MEM_DONE;
      MEM_DONE: state_nxt = IDLE;
      IF_ACC:   if (finish) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      rdata_MEM <= '0;
      if_rdata  <= '0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
      buf_full  <= 1'b0;
    end else begin
      state <= state_nxt;

      // The buffered word is consumed into IF/ID at any edge where the
      // MEM stage is not holding the pipeline.
      if (buf_full && !stall_MEM) begin
        buf_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (mem_op) begin
            ram_req   <= 1'b1;
            ram_we    <= memWrite_MEM;
            ram_addr  <= addr_MEM;
            ram_wdata <= wdata_MEM;
          end else if (if_req && !buf_full) begin
            ram_req  <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= if_addr;
          end
        end
        MEM_ACC, IF_ACC: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (finish) begin
            ram_req  <= 1'b0;
            wait_cnt <= '0;
            if (timeout) begin
              bus_err <= 1'b1;
            end
            if (state == MEM_ACC) begin
              // Stores leave the previous load result untouched.
              if (!ram_we) begin
                rdata_MEM <= fin_data;
              end
            end else begin
              if_rdata <= fin_data;
              buf_full <= 1'b1;
            end
          end
        end
        default: begin
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, a memory responder with a programmable ack delay, and a
// transaction-level reference model compared on every falling clock edge.
module tb_mem_port_arbiter;

  localparam int W        = 32;
  localparam int MAX_WAIT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          if_req       = 1'b0;
  logic [W-1:0]  if_addr      = '0;
  logic [W-1:0]  if_rdata;
  logic          if_valid;
  logic          memRead_MEM  = 1'b0;
  logic          memWrite_MEM = 1'b0;
  logic [W-1:0]  addr_MEM     = '0;
  logic [W-1:0]  wdata_MEM    = '0;
  logic [W-1:0]  rdata_MEM;
  logic          mem_done;
  logic          stall_IF;
  logic          stall_MEM;
  logic          ram_req;
  logic          ram_we;
  logic [W-1:0]  ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata    = '0;
  logic          ram_ack      = 1'b0;
  logic          bus_err;
  logic [1:0]    state_dbg;

  mem_port_arbiter #(.DATA_W(W), .MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_rdata     (if_rdata),
    .if_valid     (if_valid),
    .memRead_MEM  (memRead_MEM),
    .memWrite_MEM (memWrite_MEM),
    .addr_MEM     (addr_MEM),
    .wdata_MEM    (wdata_MEM),
    .rdata_MEM    (rdata_MEM),
    .mem_done     (mem_done),
    .stall_IF     (stall_IF),
    .stall_MEM    (stall_MEM),
    .ram_req      (ram_req),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ack      (ram_ack),
    .bus_err      (bus_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;
  int n;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver helpers ----------------
  // step: move to just after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // smp: sample point just after the falling edge.
  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  // ---------------- memory responder ----------------
  // Acks in the ack_delay-th cycle of a request; ack_delay=0 never acks.
  // Read data outside the ack cycle is junk so stray captures are visible.
  int           ack_delay = 1;
  logic [W-1:0] resp_data = '0;
  int           resp_cnt  = 0;

  initial forever begin
    @(negedge clk);
    if (ram_req) begin
      resp_cnt++;
      ram_ack   = (ack_delay != 0) && (resp_cnt == ack_delay);
      ram_rdata = ram_ack ? resp_data : 32'hBADBAD00;
    end else begin
      resp_cnt  = 0;
      ram_ack   = 1'b0;
      ram_rdata = 32'hBADBAD00;
    end
  end

  // ---------------- reference model ----------------
  // Tracks the outstanding transaction (owner and age), the one-cycle
  // completion pulse for MEM, and the fetch buffer.
  bit           m_busy   = 1'b0;
  bit           m_is_mem = 1'b0;
  int           m_age    = 0;
  bit           m_done   = 1'b0;
  bit           m_buf    = 1'b0;
  logic [W-1:0] m_word   = '0;
  logic [W-1:0] m_ld     = '0;
  bit           m_err    = 1'b0;
  logic [W-1:0] m_addr   = '0;
  logic [W-1:0] m_wdata  = '0;
  bit           m_we     = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_busy = 0; m_is_mem = 0; m_age = 0; m_done = 0; m_buf = 0;
      m_word = '0; m_ld = '0; m_err = 0; m_addr = '0; m_wdata = '0; m_we = 0;
    end else begin
      bit           mem_op;
      bit           buf_was;
      logic [W-1:0] d;
      mem_op  = memRead_MEM | memWrite_MEM;
      buf_was = m_buf;
      if (m_buf && !(mem_op && !m_done)) m_buf = 0;
      if (m_done) begin
        m_done = 0;
      end else if (!m_busy) begin
        if (mem_op) begin
          m_busy = 1; m_is_mem = 1; m_age = 0;
          m_addr = addr_MEM; m_wdata = wdata_MEM; m_we = memWrite_MEM;
        end else if (if_req && !buf_was) begin
          m_busy = 1; m_is_mem = 0; m_age = 0;
          m_addr = if_addr; m_we = 0;
        end
      end else begin
        m_age++;
        if (ram_ack || m_age == MAX_WAIT) begin
          d = ram_ack ? ram_rdata : '0;
          if (!ram_ack) m_err = 1;
          m_busy = 0;
          if (m_is_mem) begin
            if (!m_we) m_ld = d;
            m_done = 1;
          end else begin
            m_word = d;
            m_buf  = 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      chk("cyc_ram_req",   ram_req,   m_busy);
      chk("cyc_ram_we",    ram_we,    m_we);
      chk("cyc_ram_addr",  ram_addr,  m_addr);
      chk("cyc_ram_wdata", ram_wdata, m_wdata);
      chk("cyc_if_valid",  if_valid,  m_buf);
      chk("cyc_if_rdata",  if_rdata,  m_word);
      chk("cyc_rdata_mem", rdata_MEM, m_ld);
      chk("cyc_mem_done",  mem_done,  m_done);
      chk("cyc_bus_err",   bus_err,   m_err);
      chk("cyc_stall_mem", stall_MEM, rst & (memRead_MEM | memWrite_MEM) & !m_done);
      chk("cyc_stall_if",  stall_IF,  rst & if_req & !m_buf);
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset with requests asserted: stalls must still be forced low.
    rst = 1'b0; if_req = 1'b1; memRead_MEM = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_ram_req",   ram_req,   0);
    chk("rst_stall_if",  stall_IF,  0);
    chk("rst_stall_mem", stall_MEM, 0);
    chk("rst_if_valid",  if_valid,  0);
    chk("rst_mem_done",  mem_done,  0);
    chk("rst_bus_err",   bus_err,   0);
    chk("rst_state",     state_dbg, 0);
    if_req = 1'b0; memRead_MEM = 1'b0;
    step();
    rst = 1'b1; cmp_on = 1'b1;
    step();

    // 1: fetch only, single-cycle ack
    if_addr = 32'h00400000; if_req = 1'b1; ack_delay = 1; resp_data = 32'h8C010004;
    smp();
    chk("t1_stall_if_issue", stall_IF, 1);
    chk("t1_req_issue",      ram_req,  0);
    smp();
    chk("t1_req_acc",  ram_req,  1);
    chk("t1_addr_acc", ram_addr, 32'h00400000);
    chk("t1_we_acc",   ram_we,   0);
    smp();
    chk("t1_if_valid", if_valid, 1);
    chk("t1_if_rdata", if_rdata, 32'h8C010004);
    chk("t1_stall_if", stall_IF, 0);
    chk("t1_req_drop", ram_req,  0);
    step();
    if_req = 1'b0;
    smp();
    chk("t1_consumed", if_valid, 0);

    // 2: load, ack in the third request cycle
    step();
    memRead_MEM = 1'b1; addr_MEM = 32'h10010000; ack_delay = 3; resp_data = 32'h0000002A;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (!stall_MEM) break;
      n++;
    end
    chk("t2_stall_cycles", n, 4);
    chk("t2_mem_done",     mem_done,  1);
    chk("t2_rdata",        rdata_MEM, 32'h0000002A);
    step();
    memRead_MEM = 1'b0;

    // 3: simultaneous fetch and store, store goes first
    step();
    memWrite_MEM = 1'b1; addr_MEM = 32'h10010004; wdata_MEM = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h00400004; ack_delay = 1; resp_data = 32'h11112222;
    smp();
    chk("t3_req_issue",  ram_req,   0);
    chk("t3_stall_mem",  stall_MEM, 1);
    smp();
    chk("t3_req",        ram_req,   1);
    chk("t3_we",         ram_we,    1);
    chk("t3_addr",       ram_addr,  32'h10010004);
    chk("t3_wdata",      ram_wdata, 32'hDEADBEEF);
    smp();
    chk("t3_mem_done",   mem_done,  1);
    chk("t3_no_fetch",   ram_req,   0);
    chk("t3_store_keep", rdata_MEM, 32'h0000002A);
    step();
    memWrite_MEM = 1'b0;
    smp();
    chk("t3_fetch_issue", ram_req, 0);
    smp();
    chk("t3_fetch_req",  ram_req,  1);
    chk("t3_fetch_we",   ram_we,   0);
    chk("t3_fetch_addr", ram_addr, 32'h00400004);
    smp();
    chk("t3_if_rdata",   if_rdata, 32'h11112222);
    step();
    if_req = 1'b0;

    // 4: fetch completes while a load is stalled behind it
    step();
    if_req = 1'b1; if_addr = 32'h00400008; ack_delay = 2; resp_data = 32'hAAAA5555;
    smp();
    chk("t4_req_issue", ram_req, 0);
    step();
    memRead_MEM = 1'b1; addr_MEM = 32'h10010008;
    smp();
    chk("t4_fetch_addr", ram_addr,  32'h00400008);
    chk("t4_stall_mem",  stall_MEM, 1);
    smp();
    chk("t4_fetch_ack",  ram_req,   1);
    step();
    resp_data = 32'h12345678;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (!stall_MEM) break;
      chk("t4_hold_valid", if_valid, 1);
      chk("t4_hold_word",  if_rdata, 32'hAAAA5555);
      if (ram_req) chk("t4_load_addr", ram_addr, 32'h10010008);
      n++;
    end
    chk("t4_stall_cycles", n, 3);
    chk("t4_mem_done",     mem_done,  1);
    chk("t4_rdata",        rdata_MEM, 32'h12345678);
    chk("t4_valid_done",   if_valid,  1);
    step();
    memRead_MEM = 1'b0; if_req = 1'b0;
    smp();
    chk("t4_consumed", if_valid, 0);
    chk("t4_idle_req", ram_req,  0);

    // 5: load never acked, timeout
    step();
    memRead_MEM = 1'b1; addr_MEM = 32'h1001000C; ack_delay = 0;
    smp();
    chk("t5_err_before", bus_err, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!ram_req) break;
      n++;
    end
    chk("t5_req_cycles", n, MAX_WAIT);
    chk("t5_mem_done",   mem_done,  1);
    chk("t5_rdata_zero", rdata_MEM, 0);
    chk("t5_bus_err",    bus_err,   1);
    step();
    memRead_MEM = 1'b0;
    smp();
    smp();
    chk("t5_err_sticky", bus_err, 1);

    // 6: asynchronous reset in the middle of an access
    step();
    memRead_MEM = 1'b1; addr_MEM = 32'h10010010; if_req = 1'b1; if_addr = 32'h0040000C;
    smp();
    smp();
    chk("t6_req_before", ram_req,   1);
    chk("t6_stall_pre",  stall_MEM, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req_rst",   ram_req,   0);
    chk("t6_stall_mem", stall_MEM, 0);
    chk("t6_stall_if",  stall_IF,  0);
    chk("t6_mem_done",  mem_done,  0);
    chk("t6_bus_err",   bus_err,   0);
    step();
    memRead_MEM = 1'b0; if_req = 1'b0;
    step();
    rst = 1'b1;
    smp();
    chk("t6_state_idle", state_dbg, 0);
    chk("t6_err_clear",  bus_err,   0);
    chk("t6_req_idle",   ram_req,   0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
